uart_rx_byte_fifo: RTL and testbench

Upstream receive stage of the UART control path. Deserialises 8N1 frames from the `uart_rx` pin and buffers the received bytes in a show-ahead FIFO. The command parser drains this FIFO through the `fifo_data` / `fifo_data_valid` / `fifo_data_req` handshake. Framing errors and overflow are reported on status outputs.

---
 rtl/uart_ctrl_pkg.sv | 20 ++
 rtl/uart_rx_byte_fifo_if.sv | 12 +
 rtl/uart_rx_sync_fifo.sv | 47 ++++
 rtl/uart_rx_byte_fifo.sv | 143 ++++++++++++++
 tb/tb_uart_rx_byte_fifo.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_ctrl_pkg.sv
// Shared UART control-path definitions: receiver state encoding, data width, parser byte constants.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_ctrl_pkg;

  localparam int unsigned UART_DATA_W = 8;

  localparam logic [7:0] ASC_w = 8'h77;
  localparam logic [7:0] ASC_r = 8'h72;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    RX_PARITY = 3'd3,
`endif
    RX_STOP   = 3'd4
  } rx_state_t;

endpackage

// File: rtl/uart_rx_byte_fifo_if.sv
// Show-ahead byte handshake between the UART receive FIFO (master) and the command parser (slave).
interface uart_rx_byte_fifo_if;
  import uart_ctrl_pkg::*;

  logic [UART_DATA_W-1:0] fifo_data;
  logic                   fifo_data_valid;
  logic                   fifo_data_req;

  modport master (output fifo_data, output fifo_data_valid, input fifo_data_req);
  modport slave  (input fifo_data, input fifo_data_valid, output fifo_data_req);

endinterface

// File: rtl/uart_rx_sync_fifo.sv
// Show-ahead synchronous FIFO, depth 2^FIFO_AW, wrap-bit pointers, unreset storage.
// A push while full is accepted only when a pop happens in the same cycle.
module uart_rx_sync_fifo import uart_ctrl_pkg::*; #(
  parameter int unsigned FIFO_AW = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [UART_DATA_W-1:0] push_data,
  input  logic                   pop,
  output logic [UART_DATA_W-1:0] rd_data,
  output logic                   empty,
  output logic                   full,
  output logic [FIFO_AW:0]       level
);

  localparam int unsigned DEPTH = 2 ** FIFO_AW;

  logic [UART_DATA_W-1:0] mem [DEPTH];
  logic [FIFO_AW:0]       wr_ptr;
  logic [FIFO_AW:0]       rd_ptr;
  logic                   wr_en;
  logic                   rd_en;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]) &&
                   (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]);
  assign rd_en   = pop && !empty;
  assign wr_en   = push && (!full || rd_en);
  assign level   = wr_ptr - rd_ptr;
  assign rd_data = mem[rd_ptr[FIFO_AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[FIFO_AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/uart_rx_byte_fifo.sv
// UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined) feeding a show-ahead byte FIFO.
// Reports rejected frames on frame_err (1-cycle pulse) and lost bytes on sticky overflow.
module uart_rx_byte_fifo import uart_ctrl_pkg::*; #(
  parameter int unsigned CLK_DIV = 16,
  parameter int unsigned FIFO_AW = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       uart_rx,
  uart_rx_byte_fifo_if.master        fifo_if,
  output logic                       frame_err,
  output logic                       overflow,
  output logic [FIFO_AW:0]           fifo_level
);

  localparam logic [15:0] BAUD_LAST = 16'(CLK_DIV - 1);
  localparam logic [15:0] BAUD_HALF = 16'(CLK_DIV / 2 - 1);

  rx_state_t              state_q, state_d;
  logic                   rx_meta, rx_s, rx_prev;
  logic                   fall;
  logic [15:0]            baud_cnt;
  logic [2:0]             bit_cnt;
  logic [UART_DATA_W-1:0] shreg;
  logic                   data_tick;
  logic                   push;
  logic                   pop;
  logic                   fifo_empty;
  logic                   fifo_full;
`ifdef UART_RX_PARITY_EN
  logic                   par_tick;
  logic                   par_bad;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  assign fall = rx_prev && !rx_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RX_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    data_tick = 1'b0;
    push      = 1'b0;
    frame_err = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_tick  = 1'b0;
`endif
    case (state_q)
      RX_IDLE:  if (fall) state_d = RX_START;
      RX_START: if (baud_cnt == BAUD_HALF) state_d = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA: begin
        if (baud_cnt == BAUD_LAST) begin
          data_tick = 1'b1;
`ifdef UART_RX_PARITY_EN
          if (bit_cnt == 3'd7) state_d = RX_PARITY;
`else
          if (bit_cnt == 3'd7) state_d = RX_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      RX_PARITY: begin
        if (baud_cnt == BAUD_LAST) begin
          par_tick = 1'b1;
          state_d  = RX_STOP;
        end
      end
`endif
      RX_STOP: begin
        // Leave at the stop-bit centre so a back-to-back start edge is not missed.
        if (baud_cnt == BAUD_LAST) begin
          state_d = RX_IDLE;
`ifdef UART_RX_PARITY_EN
          if (rx_s && !par_bad) push = 1'b1;
          else                  frame_err = 1'b1;
`else
          if (rx_s) push = 1'b1;
          else      frame_err = 1'b1;
`endif
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
    end else begin
      if (state_d != state_q || baud_cnt == BAUD_LAST) baud_cnt <= '0;
      else                                             baud_cnt <= baud_cnt + 16'd1;

      if (state_q != RX_DATA) bit_cnt <= '0;
      else if (data_tick)     bit_cnt <= bit_cnt + 3'd1;

      if (data_tick) shreg <= {rx_s, shreg[UART_DATA_W-1:1]};
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        par_bad <= 1'b0;
    else if (par_tick) par_bad <= (^shreg) ^ rx_s;
  end
`endif

  assign pop                     = fifo_if.fifo_data_req && fifo_if.fifo_data_valid;
  assign fifo_if.fifo_data_valid = !fifo_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            overflow <= 1'b0;
    else if (push && fifo_full && !pop)    overflow <= 1'b1;
  end

  uart_rx_sync_fifo #(.FIFO_AW(FIFO_AW)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (shreg),
    .pop       (pop),
    .rd_data   (fifo_if.fifo_data),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .level     (fifo_level)
  );

endmodule

// File: tb/tb_uart_rx_byte_fifo.sv
// Directed bench for uart_rx_byte_fifo (CLK_DIV=16, FIFO_AW=2); adds a parity scenario when
// UART_RX_PARITY_EN is defined.
module tb_uart_rx_byte_fifo;
  import uart_ctrl_pkg::*;

  localparam int unsigned CLK_DIV = 16;
  localparam int unsigned FIFO_AW = 2;
  localparam int unsigned HALF    = CLK_DIV / 2;

  logic             clk     = 1'b0;
  logic             rst_n   = 1'b0;
  logic             uart_rx = 1'b1;
  logic             frame_err;
  logic             overflow;
  logic [FIFO_AW:0] fifo_level;

  int checks   = 0;
  int failures = 0;
  int fe_total = 0;

  uart_rx_byte_fifo_if fif ();

  uart_rx_byte_fifo #(.CLK_DIV(CLK_DIV), .FIFO_AW(FIFO_AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .uart_rx    (uart_rx),
    .fifo_if    (fif.master),
    .frame_err  (frame_err),
    .overflow   (overflow),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_err === 1'b1) fe_total++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    uart_rx = b;
    tick(CLK_DIV);
  endtask

  task automatic send_head(input logic [7:0] d, input logic par_flip);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^d) ^ par_flip);
`else
    if (par_flip) uart_rx = 1'b1;
`endif
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_flip);
    send_head(d, par_flip);
    send_bit(stop);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick(3);
    checks++; if (fif.fifo_data_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", fif.fifo_data_valid); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    checks++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL reset_level: got %0d expected 0", fifo_level); end
    rst_n = 1'b1;
    tick(4);
  endtask

  task automatic test_single_byte;
    int fe0 = fe_total;
    send_head(ASC_w, 1'b0);
    uart_rx = 1'b1;
    tick(HALF + 2);
    checks++; if (fif.fifo_data_valid !== 1'b0) begin failures++; $display("FAIL single_valid_early: got %b expected 0", fif.fifo_data_valid); end
    tick(1);
    checks++; if (fif.fifo_data_valid !== 1'b1) begin failures++; $display("FAIL single_valid: got %b expected 1", fif.fifo_data_valid); end
    checks++; if (fif.fifo_data !== 8'h77) begin failures++; $display("FAIL single_data: got %h expected 77", fif.fifo_data); end
    checks++; if (fifo_level !== 3'd1) begin failures++; $display("FAIL single_level: got %0d expected 1", fifo_level); end
    tick(CLK_DIV - HALF - 3);
    fif.fifo_data_req = 1'b1;
    tick(1);
    fif.fifo_data_req = 1'b0;
    checks++; if (fif.fifo_data_valid !== 1'b0) begin failures++; $display("FAIL single_pop_valid: got %b expected 0", fif.fifo_data_valid); end
    checks++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL single_pop_level: got %0d expected 0", fifo_level); end
    checks++; if (fe_total - fe0 !== 0) begin failures++; $display("FAIL single_frame_err: got %0d pulses expected 0", fe_total - fe0); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp_q [4];
    int fe0 = fe_total;
    exp_q = '{ASC_r, 8'h10, 8'h20, 8'h30};
    for (int i = 0; i < 4; i++) send_frame(exp_q[i], 1'b1, 1'b0);
    tick(4);
    checks++; if (fifo_level !== 3'd4) begin failures++; $display("FAIL b2b_level: got %0d expected 4", fifo_level); end
    checks++; if (fe_total - fe0 !== 0) begin failures++; $display("FAIL b2b_frame_err: got %0d pulses expected 0", fe_total - fe0); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (fif.fifo_data_valid !== 1'b1 || fif.fifo_data !== exp_q[i]) begin
        failures++; $display("FAIL b2b_pop%0d: got valid=%b data=%h expected valid=1 data=%h", i, fif.fifo_data_valid, fif.fifo_data, exp_q[i]);
      end
      fif.fifo_data_req = 1'b1;
      tick(1);
      fif.fifo_data_req = 1'b0;
    end
    checks++; if (fif.fifo_data_valid !== 1'b0) begin failures++; $display("FAIL b2b_empty: got %b expected 0", fif.fifo_data_valid); end
  endtask

  task automatic test_framing_error;
    int fe0 = fe_total;
    send_head(8'hA5, 1'b0);
    uart_rx = 1'b0;
    tick(HALF + 2);
    checks++; if (frame_err !== 1'b1) begin failures++; $display("FAIL ferr_pulse: got %b expected 1", frame_err); end
    tick(1);
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL ferr_pulse_end: got %b expected 0", frame_err); end
    tick(CLK_DIV - HALF - 3);
    uart_rx = 1'b1;
    tick(2 * CLK_DIV);
    checks++; if (fe_total - fe0 !== 1) begin failures++; $display("FAIL ferr_count: got %0d pulses expected 1", fe_total - fe0); end
    checks++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL ferr_level: got %0d expected 0", fifo_level); end
    send_frame(8'h5A, 1'b1, 1'b0);
    tick(4);
    checks++; if (fifo_level !== 3'd1 || fif.fifo_data !== 8'h5A) begin
      failures++; $display("FAIL ferr_recover: got level=%0d data=%h expected level=1 data=5a", fifo_level, fif.fifo_data);
    end
    fif.fifo_data_req = 1'b1;
    tick(1);
    fif.fifo_data_req = 1'b0;
  endtask

  task automatic test_glitch;
    int fe0 = fe_total;
    uart_rx = 1'b0;
    tick(3);
    uart_rx = 1'b1;
    tick(2 * CLK_DIV);
    checks++; if (fifo_level !== 3'd0 || fif.fifo_data_valid !== 1'b0) begin
      failures++; $display("FAIL glitch_push: got level=%0d valid=%b expected level=0 valid=0", fifo_level, fif.fifo_data_valid);
    end
    checks++; if (fe_total - fe0 !== 0) begin failures++; $display("FAIL glitch_frame_err: got %0d pulses expected 0", fe_total - fe0); end
  endtask

  task automatic test_overflow;
    logic [7:0] exp_q [4];
    exp_q = '{8'h02, 8'h03, 8'h04, 8'h06};
    for (int k = 1; k <= 4; k++) send_frame(8'(k), 1'b1, 1'b0);
    tick(2);
    checks++; if (fifo_level !== 3'd4 || overflow !== 1'b0) begin
      failures++; $display("FAIL ovf_full: got level=%0d overflow=%b expected level=4 overflow=0", fifo_level, overflow);
    end
    send_head(8'h05, 1'b0);
    uart_rx = 1'b1;
    tick(HALF + 2);
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_early: got %b expected 0", overflow); end
    tick(1);
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set: got %b expected 1", overflow); end
    checks++; if (fifo_level !== 3'd4 || fif.fifo_data !== 8'h01) begin
      failures++; $display("FAIL ovf_contents: got level=%0d head=%h expected level=4 head=01", fifo_level, fif.fifo_data);
    end
    tick(CLK_DIV - HALF - 3);
    send_head(8'h06, 1'b0);
    uart_rx = 1'b1;
    tick(HALF + 2);
    fif.fifo_data_req = 1'b1;
    tick(1);
    fif.fifo_data_req = 1'b0;
    checks++; if (fifo_level !== 3'd4 || fif.fifo_data !== 8'h02) begin
      failures++; $display("FAIL ovf_push_pop: got level=%0d head=%h expected level=4 head=02", fifo_level, fif.fifo_data);
    end
    tick(CLK_DIV - HALF - 3);
    for (int i = 0; i < 4; i++) begin
      checks++; if (fif.fifo_data_valid !== 1'b1 || fif.fifo_data !== exp_q[i]) begin
        failures++; $display("FAIL ovf_pop%0d: got valid=%b data=%h expected valid=1 data=%h", i, fif.fifo_data_valid, fif.fifo_data, exp_q[i]);
      end
      fif.fifo_data_req = 1'b1;
      tick(1);
      fif.fifo_data_req = 1'b0;
    end
    checks++; if (overflow !== 1'b1 || fifo_level !== 3'd0) begin
      failures++; $display("FAIL ovf_sticky: got overflow=%b level=%0d expected overflow=1 level=0", overflow, fifo_level);
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    int fe0 = fe_total;
    send_frame(8'h03, 1'b1, 1'b1);
    tick(4);
    checks++; if (fe_total - fe0 !== 1 || fifo_level !== 3'd0) begin
      failures++; $display("FAIL parity_reject: got pulses=%0d level=%0d expected pulses=1 level=0", fe_total - fe0, fifo_level);
    end
    send_frame(8'h07, 1'b0, 1'b1);
    uart_rx = 1'b1;
    tick(4);
    checks++; if (fe_total - fe0 !== 2) begin failures++; $display("FAIL parity_double: got %0d pulses expected 2", fe_total - fe0); end
    send_frame(8'h07, 1'b1, 1'b0);
    tick(4);
    checks++; if (fifo_level !== 3'd1 || fif.fifo_data !== 8'h07) begin
      failures++; $display("FAIL parity_accept: got level=%0d data=%h expected level=1 data=07", fifo_level, fif.fifo_data);
    end
    fif.fifo_data_req = 1'b1;
    tick(1);
    fif.fifo_data_req = 1'b0;
  endtask
`endif

  task automatic test_reset_mid_frame;
    int fe0;
    send_frame(ASC_w, 1'b1, 1'b0);
    tick(2);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    rst_n = 1'b0;
    #2;
    checks++; if (fif.fifo_data_valid !== 1'b0 || fifo_level !== 3'd0) begin
      failures++; $display("FAIL rst_mid_fifo: got valid=%b level=%0d expected valid=0 level=0", fif.fifo_data_valid, fifo_level);
    end
    checks++; if (overflow !== 1'b0 || frame_err !== 1'b0) begin
      failures++; $display("FAIL rst_mid_flags: got overflow=%b frame_err=%b expected 0 0", overflow, frame_err);
    end
    uart_rx = 1'b1;
    tick(3);
    rst_n = 1'b1;
    fe0 = fe_total;
    tick(12 * CLK_DIV);
    checks++; if (fe_total - fe0 !== 0 || fifo_level !== 3'd0) begin
      failures++; $display("FAIL rst_mid_quiet: got pulses=%0d level=%0d expected 0 0", fe_total - fe0, fifo_level);
    end
    send_frame(ASC_r, 1'b1, 1'b0);
    tick(4);
    checks++; if (fifo_level !== 3'd1 || fif.fifo_data !== 8'h72) begin
      failures++; $display("FAIL rst_mid_recover: got level=%0d data=%h expected level=1 data=72", fifo_level, fif.fifo_data);
    end
    fif.fifo_data_req = 1'b1;
    tick(1);
    fif.fifo_data_req = 1'b0;
  endtask

  initial begin
    fif.fifo_data_req = 1'b0;
    #1;
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_framing_error();
    test_glitch();
    test_overflow();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
